// File: rtl/clkroot_div.sv
// -----------------------------------------------------------------------------
// clkroot_div
//
// Programmable integer clock divider producing a glitch-free derived clock
// root from clk. The divided clock comes from one posedge flop, optionally
// ORed with a negedge flop for 50% duty on odd divisors. It leaves through a
// keep-attributed anchor buffer so timing constraints can find the generated
// clock. Supports run/stop and safe on-the-fly divisor changes applied only at
// period boundaries.
//
// Build option:
//   CLKROOT_DIV_DUTY50_EN  - when defined, odd divisors get exactly N/2 cycles
//                            high (half-cycle extension via a negedge flop).
//                            When undefined, odd N is (N+1)/2 high, (N-1)/2 low.
//
// Parameters:
//   W_DIV      divisor width; legal divisors 2..2^W_DIV-1
//   DIV_RESET  divisor in effect after reset (>= 2)
//
// Ports:
//   clk         in   source clock
//   rst_n       in   asynchronous active-low reset
//   en          in   run request, sampled on clk rising edge
//   div_wdata   in   new divisor value
//   div_wen     in   one-cycle strobe loading div_wdata into the pending reg
//   div_busy    out  a pending divisor exists and is not yet applied
//   div_active  out  divisor currently in effect
//   running     out  divider is in the RUN state
//   tick        out  high for the first clk cycle of each clk_out high phase
//   clk_out     out  divided clock, driven through the anchor buffer
// -----------------------------------------------------------------------------

// Clock-root anchor: a named, kept buffer that marks where the generated clock
// originates so constraints can reference a stable pin.
module clkroot_div_anchor (
    input  logic i_clk,
    output logic o_clk
);
    assign o_clk = i_clk;
endmodule

module clkroot_div #(
    parameter int W_DIV     = 8,
    parameter int DIV_RESET = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [W_DIV-1:0] div_wdata,
    input  logic             div_wen,
    output logic             div_busy,
    output logic [W_DIV-1:0] div_active,
    output logic             running,
    output logic             tick,
    output logic             clk_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [W_DIV-1:0] DIV_MIN  = W_DIV'(2);
    localparam logic [W_DIV-1:0] DIV_INIT = W_DIV'(DIV_RESET);

    // Number of leading counter values for which the posedge flop is high.
    function automatic logic [W_DIV-1:0] hi_of(input logic [W_DIV-1:0] n);
`ifdef CLKROOT_DIV_DUTY50_EN
        // Odd N gets floor(N/2); the negedge flop adds the missing half cycle.
        return n >> 1;
`else
        // ceil(N/2): odd N spends the extra cycle in the high phase.
        return (n >> 1) + {{(W_DIV-1){1'b0}}, n[0]};
`endif
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [W_DIV-1:0] r_ctr;
    logic [W_DIV-1:0] r_div_active;
    logic [W_DIV-1:0] r_div_pend;
    logic             r_busy;
    logic             r_clk_pos;
    logic             r_tick;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    state_t           w_state_next;
    logic [W_DIV-1:0] w_ctr_next;
    logic [W_DIV-1:0] w_div_next;
    logic [W_DIV-1:0] w_pend_next;
    logic             w_busy_next;
    logic             w_last;
    logic             w_apply;
    logic             w_clk_pos_next;
    logic             w_tick_next;

    assign w_last = (r_ctr == (r_div_active - W_DIV'(1)));

    // A period boundary where a new period will start: either leaving IDLE or
    // wrapping while still enabled. Only here may the divisor change, which
    // guarantees the in-progress period finishes with the old N.
    assign w_apply = en && ((r_state == IDLE) || w_last);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        w_state_next = r_state;
        w_ctr_next   = r_ctr;
        w_div_next   = r_div_active;
        w_pend_next  = r_div_pend;
        w_busy_next  = r_busy;

        unique case (r_state)
            IDLE: begin
                w_ctr_next = '0;
                if (en) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_ctr_next = '0;
                    if (!en) begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_ctr_next = r_ctr + W_DIV'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_ctr_next   = '0;
            end
        endcase

        // Apply the old pending value before a same-cycle write replaces it,
        // so a write coinciding with a boundary stays pending for the next one.
        if (w_apply && r_busy) begin
            w_div_next  = r_div_pend;
            w_busy_next = 1'b0;
        end

        if (div_wen) begin
            w_pend_next = (div_wdata < DIV_MIN) ? DIV_MIN : div_wdata;
            w_busy_next = 1'b1;
        end
    end

    // Outputs are computed from next-state values so they are registered yet
    // aligned with the counter; the high-phase length uses the divisor of the
    // period that the next counter value belongs to.
    assign w_clk_pos_next = (w_state_next == RUN) && (w_ctr_next < hi_of(w_div_next));
    assign w_tick_next    = (w_state_next == RUN) && (w_ctr_next == '0);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ctr        <= '0;
            r_div_active <= DIV_INIT;
            r_div_pend   <= DIV_INIT;
            r_busy       <= 1'b0;
            r_clk_pos    <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ctr        <= w_ctr_next;
            r_div_active <= w_div_next;
            r_div_pend   <= w_pend_next;
            r_busy       <= w_busy_next;
            r_clk_pos    <= w_clk_pos_next;
            r_tick       <= w_tick_next;
        end
    end

    // -------------------------------------------------------------------------
    // Clock root
    // -------------------------------------------------------------------------
    logic w_clk_root;

`ifdef CLKROOT_DIV_DUTY50_EN
    logic r_clk_neg;

    // Half-cycle extension for odd divisors. The posedge flop only changes on
    // rising edges and this one only on falling edges, so the OR cannot
    // glitch. div_active updates on the same edge the high phase starts, and
    // by the time it changes the previous period's extension has already
    // ended, so masking with it is safe across divisor changes.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_neg <= 1'b0;
        end else begin
            r_clk_neg <= r_clk_pos & r_div_active[0];
        end
    end

    assign w_clk_root = r_clk_pos | r_clk_neg;
`else
    assign w_clk_root = r_clk_pos;
`endif

    (* keep = "true", dont_touch = "true" *)
    clkroot_div_anchor u_clk_anchor (
        .i_clk (w_clk_root),
        .o_clk (clk_out)
    );

    assign div_busy   = r_busy;
    assign div_active = r_div_active;
    assign running    = (r_state == RUN);
    assign tick       = r_tick;

endmodule

// File: tb/tb_clkroot_div.sv
// -----------------------------------------------------------------------------
// tb_clkroot_div
//
// Self-checking bench for clkroot_div. The reference model describes each
// clk_out period as a list of per-cycle waveform samples (first-half value,
// second-half value, tick) built from the divisor with plain arithmetic; a
// new period is scheduled whenever the previous list runs out.
// -----------------------------------------------------------------------------
module tb_clkroot_div;

    localparam int W_DIV     = 8;
    localparam int DIV_RESET = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [W_DIV-1:0] div_wdata;
    logic             div_wen;
    logic             div_busy;
    logic [W_DIV-1:0] div_active;
    logic             running;
    logic             tick;
    logic             clk_out;

    clkroot_div #(
        .W_DIV     (W_DIV),
        .DIV_RESET (DIV_RESET)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .div_wdata  (div_wdata),
        .div_wen    (div_wen),
        .div_busy   (div_busy),
        .div_active (div_active),
        .running    (running),
        .tick       (tick),
        .clk_out    (clk_out)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic h1;   // clk_out during first half of the cycle
        logic h2;   // clk_out during second half of the cycle
        logic tk;   // tick during this cycle
    } cyc_t;

    cyc_t m_q[$];
    cyc_t m_cur;
    int   m_active;
    int   m_pend;
    bit   m_busy;
    bit   m_running;
    int   m_pos;

    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur     = '0;
        m_active  = DIV_RESET;
        m_pend    = DIV_RESET;
        m_busy    = 1'b0;
        m_running = 1'b0;
        m_pos     = 0;
    endtask

    // Waveform of one full period of divisor n.
    task automatic schedule_period(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c.tk = (i == 0);
`ifdef CLKROOT_DIV_DUTY50_EN
            if (i < n / 2)                      begin c.h1 = 1'b1; c.h2 = 1'b1; end
            else if ((n % 2 == 1) && i == n / 2) begin c.h1 = 1'b1; c.h2 = 1'b0; end
            else                                 begin c.h1 = 1'b0; c.h2 = 1'b0; end
`else
            c.h1 = (i < (n + 1) / 2);
            c.h2 = c.h1;
`endif
            m_q.push_back(c);
        end
    endtask

    // One clk cycle: advance the model on the rising edge using the inputs
    // the DUT samples there, then compare both halves of the cycle.
    task automatic step();
        @(posedge clk);
        if (m_q.size() == 0) begin
            if (en) begin
                if (m_busy) begin
                    m_active = m_pend;
                    m_busy   = 1'b0;
                end
                schedule_period(m_active);
                m_running = 1'b1;
                m_pos     = -1;
            end else begin
                m_running = 1'b0;
            end
        end
        if (m_q.size() != 0) begin
            m_cur = m_q.pop_front();
            m_pos++;
        end else begin
            m_cur = '0;
        end
        if (div_wen) begin
            m_pend = (div_wdata < 2) ? 2 : int'(div_wdata);
            m_busy = 1'b1;
        end
        #1;
        check("clk_out",    32'(clk_out),    32'(m_cur.h1));
        check("tick",       32'(tick),       32'(m_cur.tk));
        check("running",    32'(running),    32'(m_running));
        check("div_busy",   32'(div_busy),   32'(m_busy));
        check("div_active", 32'(div_active), 32'(m_active));
        @(negedge clk);
        #1;
        check("clk_out_2nd_half", 32'(clk_out), 32'(m_cur.h2));
    endtask

    task automatic write_div(input int v);
        div_wen   = 1'b1;
        div_wdata = W_DIV'(v);
        step();
        div_wen   = 1'b0;
    endtask

    // Asynchronous reset: outputs must fall without waiting for a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_clk_out",    32'(clk_out),    0);
        check("rst_tick",       32'(tick),       0);
        check("rst_running",    32'(running),    0);
        check("rst_div_busy",   32'(div_busy),   0);
        check("rst_div_active", 32'(div_active), DIV_RESET);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n     = 1'b1;
        en        = 1'b0;
        div_wen   = 1'b0;
        div_wdata = '0;
        #3;
        do_reset();

        // Default divisor, free running.
        en = 1'b1;
        repeat (8) step();

        // Load 5 mid-period; switch happens at the next wrap.
        write_div(5);
        repeat (20) step();
        check("active_5", 32'(div_active), 5);

        // Two back-to-back writes mid-period: only the last is applied.
        for (k = 0; k < 20 && m_pos != 1; k++) step();
        check("reach_pos1", 32'(m_pos), 1);
        write_div(7);
        write_div(9);
        check("busy_after_7_9", 32'(div_busy), 1);
        repeat (25) step();
        check("active_9", 32'(div_active), 9);

        // N=6: drop en early in a period; period completes, then stays low.
        write_div(6);
        for (k = 0; k < 40 && !(m_active == 6 && m_pos == 1); k++) step();
        check("reach_n6_pos1", 32'(m_active == 6 && m_pos == 1), 1);
        en = 1'b0;
        repeat (12) step();
        check("stopped", 32'(running), 0);
        check("stopped_low", 32'(clk_out), 0);
        en = 1'b1;
        step();
        check("restart_high", 32'(clk_out), 1);
        repeat (8) step();

        // Pending divisor survives IDLE until the next start.
        en = 1'b0;
        repeat (10) step();
        write_div(4);
        repeat (3) step();
        check("idle_pending", 32'(div_busy), 1);
        en = 1'b1;
        repeat (10) step();

        // Clamp of 0 to 2.
        write_div(0);
        repeat (12) step();
        check("clamp_0", 32'(div_active), 2);

        // Largest divisor.
        write_div(255);
        repeat (520) step();
        check("active_255", 32'(div_active), 255);

        // Reset while clk_out is high with a write pending.
        write_div(3);
        for (k = 0; k < 300 && !(m_cur.h2 && m_busy); k++) step();
        check("pre_rst_clk_high", 32'(clk_out), 1);
        check("pre_rst_busy", 32'(div_busy), 1);
        do_reset();
        step();
        check("post_rst_busy", 32'(div_busy), 0);
        check("post_rst_active", 32'(div_active), DIV_RESET);
        repeat (6) step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 99) < 85);
            div_wen = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) div_wdata = W_DIV'($urandom_range(0, 255));
            else                           div_wdata = W_DIV'($urandom_range(0, 12));
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            step();
        end
        div_wen = 1'b0;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
